// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered RISC-V immediate generator behind a 2-entry skid buffer
// Optional feature macro IMM_GEN_PIPE_ERR_EN adds err, err_sticky and err_clr.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_ext,
    output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_PIPE_ERR_EN
    ,
    input  logic             err_clr,
    output logic             err,
    output logic             err_sticky
`endif
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
`ifdef IMM_GEN_PIPE_ERR_EN
        logic             err;
`endif
    } entry_t;

    logic [XLEN-1:0] imm_dec;
    entry_t          in_ent;
    entry_t          main_d, main_q;
    entry_t          skid_d, skid_q;
    logic            main_valid_d, main_valid_q;
    logic            skid_valid_d, skid_valid_q;
    logic            in_fire, out_fire;

    // Sized casts of signed operands sign-extend to XLEN; unsigned ones zero-extend.
    always_comb begin
        imm_dec = '0;
        case (immsrc)
            3'b000: imm_dec = XLEN'($signed(instr[31:20]));
            3'b001: imm_dec = XLEN'($signed({instr[31:25], instr[11:7]}));
            3'b010: imm_dec = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            3'b011: imm_dec = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            3'b100: imm_dec = XLEN'($signed({instr[31:12], 12'b0}));
            3'b101: begin
                if (XLEN == 64) imm_dec = XLEN'(instr[25:20]);
                else            imm_dec = XLEN'(instr[24:20]);
            end
            3'b110: imm_dec = XLEN'(instr[19:15]);
            default: imm_dec = '0;
        endcase
    end

    always_comb begin
        in_ent     = '0;
        in_ent.imm = imm_dec;
        in_ent.tag = in_tag;
`ifdef IMM_GEN_PIPE_ERR_EN
        in_ent.err = (immsrc == 3'b111);
`endif
    end

    assign in_ready = !skid_valid_q;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_valid_q & out_ready;

    // The valid pair encodes EMPTY / ONE / FULL; skid only fills while main is stalled.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (out_fire) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_d = in_ent;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            if (!main_valid_q) begin
                main_d       = in_ent;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = in_ent;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid = main_valid_q;
    assign imm_ext   = main_q.imm;
    assign out_tag   = main_q.tag;

`ifdef IMM_GEN_PIPE_ERR_EN
    logic err_sticky_d, err_sticky_q;

    // A fresh illegal fire overrides a same-cycle clear.
    always_comb begin
        err_sticky_d = (err_sticky_q & ~err_clr) | (in_fire & (immsrc == 3'b111));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_sticky_q <= 1'b0;
        else       err_sticky_q <= err_sticky_d;
    end

    assign err        = main_q.err;
    assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - bench for imm_gen_pipe at XLEN=32 and XLEN=64 with a queue model
module tb_imm_gen_pipe;
    localparam int TW = 5;

    typedef struct packed {
        logic [63:0]   imm;
        logic [TW-1:0] tag;
        logic          err;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0]   a_instr;
    logic [2:0]    a_src;
    logic [TW-1:0] a_in_tag, a_out_tag;
    logic [31:0]   a_imm;

    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0]   b_instr;
    logic [2:0]    b_src;
    logic [TW-1:0] b_in_tag, b_out_tag;
    logic [63:0]   b_imm;

`ifdef IMM_GEN_PIPE_ERR_EN
    logic a_err_clr, a_err, a_err_sticky;
    logic b_err_clr, b_err, b_err_sticky;
    logic sticky_m;
`endif

    int n_cmp, n_bad;
    ent_t q32[$];
    ent_t q64[$];

    imm_gen_pipe #(.XLEN(32), .TAG_W(TW)) dut32 (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .instr(a_instr), .immsrc(a_src), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .imm_ext(a_imm), .out_tag(a_out_tag)
`ifdef IMM_GEN_PIPE_ERR_EN
        , .err_clr(a_err_clr), .err(a_err), .err_sticky(a_err_sticky)
`endif
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TW)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .instr(b_instr), .immsrc(b_src), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .imm_ext(b_imm), .out_tag(b_out_tag)
`ifdef IMM_GEN_PIPE_ERR_EN
        , .err_clr(b_err_clr), .err(b_err), .err_sticky(b_err_sticky)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint fld(input logic [31:0] w, input int hi, input int lo);
        longint x;
        x = longint'({32'd0, w});
        return (x >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
    endfunction

    // Immediate value as a signed integer, built from bit-field weights.
    function automatic logic [63:0] model_imm(input logic [31:0] w, input logic [2:0] src, input int xlen);
        longint v;
        case (src)
            3'd0: v = fld(w, 31, 20) - (w[31] ? 4096 : 0);
            3'd1: v = fld(w, 31, 25) * 32 + fld(w, 11, 7) - (w[31] ? 4096 : 0);
            3'd2: v = fld(w, 7, 7) * 2048 + fld(w, 30, 25) * 32 + fld(w, 11, 8) * 2 - (w[31] ? 4096 : 0);
            3'd3: v = fld(w, 19, 12) * 4096 + fld(w, 20, 20) * 2048 + fld(w, 30, 21) * 2
                      - (w[31] ? 1048576 : 0);
            3'd4: v = fld(w, 31, 12) * 4096 - (w[31] ? 64'sh1_0000_0000 : 64'sd0);
            3'd5: v = (xlen == 64) ? fld(w, 25, 20) : fld(w, 24, 20);
            3'd6: v = fld(w, 19, 15);
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic ent_t mk(input logic [31:0] w, input logic [2:0] s, input logic [TW-1:0] t, input int xlen);
        ent_t e;
        e.imm = model_imm(w, s, xlen);
        e.tag = t;
        e.err = (s == 3'd7);
        return e;
    endfunction

    // Occupancy, ordering and payload of both DUTs against the FIFO model.
    always @(negedge clk) begin
        ent_t e;
        if (reset) begin
            q32.delete();
            q64.delete();
`ifdef IMM_GEN_PIPE_ERR_EN
            sticky_m = 1'b0;
`endif
        end else begin
            chk("a_out_valid", a_out_valid, q32.size() > 0);
            chk("a_in_ready", a_in_ready, q32.size() < 2);
            chk("b_out_valid", b_out_valid, q64.size() > 0);
            chk("b_in_ready", b_in_ready, q64.size() < 2);
`ifdef IMM_GEN_PIPE_ERR_EN
            chk("a_err_sticky", a_err_sticky, sticky_m);
            sticky_m = (sticky_m & ~a_err_clr) | (a_in_valid & a_in_ready & (a_src == 3'd7));
`endif
            if (a_out_valid && a_out_ready && q32.size() > 0) begin
                e = q32.pop_front();
                chk("a_imm", a_imm, e.imm[31:0]);
                chk("a_tag", a_out_tag, e.tag);
`ifdef IMM_GEN_PIPE_ERR_EN
                chk("a_err", a_err, e.err);
`endif
            end
            if (b_out_valid && b_out_ready && q64.size() > 0) begin
                e = q64.pop_front();
                chk("b_imm", b_imm, e.imm);
                chk("b_tag", b_out_tag, e.tag);
            end
            if (a_in_valid && a_in_ready) q32.push_back(mk(a_instr, a_src, a_in_tag, 32));
            if (b_in_valid && b_in_ready) q64.push_back(mk(b_instr, b_src, b_in_tag, 64));
        end
    end

    task automatic send_a(input string name, input logic [31:0] w, input logic [2:0] s,
                          input logic [TW-1:0] t, input logic [31:0] exp);
        a_in_valid = 1'b1; a_instr = w; a_src = s; a_in_tag = t;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        chk({name, "_valid"}, a_out_valid, 1'b1);
        chk(name, a_imm, exp);
    endtask

    task automatic send_b(input string name, input logic [31:0] w, input logic [2:0] s,
                          input logic [TW-1:0] t, input logic [63:0] exp);
        b_in_valid = 1'b1; b_instr = w; b_src = s; b_in_tag = t;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        chk({name, "_valid"}, b_out_valid, 1'b1);
        chk(name, b_imm, exp);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        reset = 1'b1;
        a_in_valid = 0; a_instr = 0; a_src = 0; a_in_tag = 0; a_out_ready = 1;
        b_in_valid = 0; b_instr = 0; b_src = 0; b_in_tag = 0; b_out_ready = 1;
`ifdef IMM_GEN_PIPE_ERR_EN
        a_err_clr = 0; b_err_clr = 0; sticky_m = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_imm", a_imm, 32'h0);
        chk("rst_tag", a_out_tag, 5'd0);
        chk("rst_in_ready", a_in_ready, 1'b1);
        chk("rst_imm64", b_imm, 64'h0);
        reset = 1'b0;

        send_a("i32", 32'hFFF00093, 3'd0, 5'd1, 32'hFFFFFFFF);
        send_a("s32", 32'hFE20AE23, 3'd1, 5'd2, 32'hFFFFFFFC);
        send_a("b32", 32'hFE000CE3, 3'd2, 5'd3, 32'hFFFFFFF8);
        send_a("j32", 32'h0010006F, 3'd3, 5'd4, 32'h00000800);
        send_a("u32", 32'h80000537, 3'd4, 5'd5, 32'h80000000);
        send_a("shamt32", 32'h03F00013, 3'd5, 5'd6, 32'h0000001F);
        send_a("zimm32", 32'h000F8073, 3'd6, 5'd7, 32'h0000001F);
        send_a("ill32", 32'hFFFFFFFF, 3'd7, 5'd8, 32'h0);

        send_b("u64", 32'h80000537, 3'd4, 5'd1, 64'hFFFFFFFF80000000);
        send_b("shamt64", 32'h03F00013, 3'd5, 5'd2, 64'h000000000000003F);
        send_b("zimm64", 32'h000F8073, 3'd6, 5'd3, 64'h000000000000001F);
        send_b("i64", 32'hFFF00093, 3'd0, 5'd4, 64'hFFFFFFFFFFFFFFFF);
        send_b("b64", 32'hFE000CE3, 3'd2, 5'd5, 64'hFFFFFFFFFFFFFFF8);
        @(posedge clk); #1;

        // Backpressure: two accepts fill main and skid.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_instr = 32'h00500093; a_src = 3'd0; a_in_tag = 5'd1;
        @(posedge clk); #1;
        chk("bp_ready_one", a_in_ready, 1'b1);
        a_instr = 32'h00A00113; a_in_tag = 5'd2;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        chk("bp_ready_full", a_in_ready, 1'b0);
        chk("bp_head_tag", a_out_tag, 5'd1);
        @(posedge clk); #1;
        chk("bp_stall_tag", a_out_tag, 5'd1);
        chk("bp_stall_imm", a_imm, 32'h5);
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_second_tag", a_out_tag, 5'd2);
        chk("bp_ready_back", a_in_ready, 1'b1);
        @(posedge clk); #1;
        chk("bp_drained", a_out_valid, 1'b0);

        // Streaming with continuous valid and ready.
        for (int i = 0; i < 8; i++) begin
            a_in_valid = 1'b1; a_in_tag = TW'(i);
            a_src = 3'(i % 7); a_instr = 32'(i) * 32'h13579BDF;
            if (i > 0) begin
                chk("stream_valid", a_out_valid, 1'b1);
                chk("stream_tag", a_out_tag, 64'(i - 1));
            end
            chk("stream_ready", a_in_ready, 1'b1);
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        chk("stream_last_tag", a_out_tag, 5'd7);
        @(posedge clk); #1;

        // Asynchronous reset while FULL.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_instr = 32'h12345093; a_src = 3'd0; a_in_tag = 5'd11;
        @(posedge clk); #1;
        a_in_tag = 5'd12;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        chk("full_before_rst", a_in_ready, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", a_out_valid, 1'b0);
        chk("arst_imm", a_imm, 32'h0);
        chk("arst_tag", a_out_tag, 5'd0);
        chk("arst_in_ready", a_in_ready, 1'b1);
        @(negedge clk); #2 reset = 1'b0;
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        send_a("post_rst", 32'hFFF00093, 3'd0, 5'd9, 32'hFFFFFFFF);
        chk("post_rst_tag", a_out_tag, 5'd9);
        @(posedge clk); #1;

`ifdef IMM_GEN_PIPE_ERR_EN
        send_a("err_ill", 32'hFFFFFFFF, 3'd7, 5'd3, 32'h0);
        chk("err_flag", a_err, 1'b1);
        chk("err_sticky_set", a_err_sticky, 1'b1);
        send_a("err_legal", 32'hFFF00093, 3'd0, 5'd4, 32'hFFFFFFFF);
        chk("err_flag_clr", a_err, 1'b0);
        chk("err_sticky_hold", a_err_sticky, 1'b1);
        a_err_clr = 1'b1;
        @(posedge clk); #1;
        a_err_clr = 1'b0;
        chk("err_sticky_cleared", a_err_sticky, 1'b0);
        a_err_clr = 1'b1;
        send_a("err_ill2", 32'h0, 3'd7, 5'd5, 32'h0);
        a_err_clr = 1'b0;
        chk("err_set_wins", a_err_sticky, 1'b1);
        @(posedge clk); #1;
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
